// File: rtl/adc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_seq_pkg : state codes, default parameters and helpers for adc_seq |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package adc_seq_pkg;

    localparam int          ADC_MAX_DEF = 8;
    localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;

    localparam int ST_W = 8;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 8'h00;
    localparam state_t ST_CHECK = 8'h01;
    localparam state_t ST_CONF  = 8'h02;
    localparam state_t ST_PREP  = 8'h03;
    localparam state_t ST_FITX  = 8'h04;
    localparam state_t ST_FIRX  = 8'h05;
    localparam state_t ST_CONT  = 8'h06;
    localparam state_t ST_DTRX  = 8'h07;
    localparam state_t ST_LAST  = 8'h08;
    localparam state_t ST_DONE  = 8'h09;
    localparam state_t ST_ERR   = 8'h0F;

    // A zero request still sequences one channel; oversize requests saturate.
    function automatic logic [7:0] clamp_cnt(input logic [7:0] req, input logic [7:0] lim);
        if (req == 8'd0) begin
            return 8'd1;
        end else if (req > lim) begin
            return lim;
        end
        return req;
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_CHECK) || (s == ST_CONF) || (s == ST_PREP) ||
               (s == ST_FITX)  || (s == ST_FIRX) || (s == ST_DTRX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_seq_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_wdog : per-state watchdog, flags expiry on the TIMEOUT-th cycle   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_wdog #(
    parameter int          TO_W    = 16,
    parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count holds cycles already spent, so expiry fires during cycle TIMEOUT.
    localparam logic [TO_W-1:0] C_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/adc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_seq : multi-channel ADC frame sequencer with watchdog and error   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module adc_seq
    import adc_seq_pkg::*;
#(
    parameter int          ADC_MAX = ADC_MAX_DEF,
    parameter int          TO_W    = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic        stop,
    input  logic        err_clr,
    input  logic [7:0]  adc_cnt,
    input  logic        fifo_full,
    output logic        fs_check,
    output logic        fs_conf,
    output logic        fs_read,
    output logic        fs_fifo,
    output logic        fs_dtrx,
    input  logic        fd_check,
    input  logic        fd_conf,
    input  logic        fd_read,
    input  logic        fd_fifo,
    input  logic        fd_dtrx,
    output logic [7:0]  adc_num,
    output logic [7:0]  state_o,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_code,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] C_ADC_MAX = 8'(ADC_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt_l;
    logic        r_mode_l;
    logic        r_stop_req;
    logic [7:0]  r_adc_num;
    logic [7:0]  r_err_code;
    logic [15:0] r_frame_cnt;

    logic w_expired;
    logic w_changing;
    logic w_start_ok;
    logic w_dtrx_ok;
    logic w_to_err;
    logic w_stop_pend;
    logic w_enter_rest;

    assign w_changing   = (w_next != r_state);
    assign w_start_ok   = (r_state == ST_IDLE) && start;
    assign w_dtrx_ok    = (r_state == ST_DTRX) && fd_dtrx;
    assign w_to_err     = (w_next == ST_ERR) && (r_state != ST_ERR);
    assign w_enter_rest = w_changing && ((w_next == ST_DONE) || (w_next == ST_IDLE));
    // A stop arriving in the same cycle as the frame-end handshake still counts.
    assign w_stop_pend  = r_stop_req || (stop && r_mode_l);

    seq_wdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (w_changing),
        .enable  (is_wait_state(r_state)),
        .expired (w_expired)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Done handshakes are tested before expiry so a late fd_* still wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CHECK;
            ST_CHECK: begin
                if (fd_check)       w_next = ST_CONF;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_CONF: begin
                if (fd_conf)        w_next = ST_PREP;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_PREP: begin
                if (!fifo_full)     w_next = ST_FITX;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_FITX: begin
                if (fd_read)        w_next = ST_FIRX;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_FIRX: begin
                if (fd_fifo)        w_next = ST_CONT;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_CONT: begin
                if (r_adc_num < (r_cnt_l - 8'd1)) w_next = ST_LAST;
                else                              w_next = ST_DTRX;
            end
            ST_LAST:  w_next = ST_PREP;
            ST_DTRX: begin
                if (fd_dtrx)        w_next = (r_mode_l && !w_stop_pend) ? ST_PREP : ST_DONE;
                else if (w_expired) w_next = ST_ERR;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   if (err_clr) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fs_check = (r_state == ST_CHECK);
        fs_conf  = (r_state == ST_CONF);
        fs_read  = (r_state == ST_FITX);
        fs_fifo  = (r_state == ST_FIRX);
        fs_dtrx  = (r_state == ST_DTRX);
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        err      = (r_state == ST_ERR);
        state_o  = r_state;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cnt_l     <= 8'd1;
            r_mode_l    <= 1'b0;
            r_stop_req  <= 1'b0;
            r_adc_num   <= 8'd0;
            r_err_code  <= 8'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_cnt_l  <= clamp_cnt(adc_cnt, C_ADC_MAX);
                r_mode_l <= mode;
            end

            if (w_enter_rest) begin
                r_stop_req <= 1'b0;
            end else if (stop && r_mode_l && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
                r_stop_req <= 1'b1;
            end

            if (w_start_ok || w_dtrx_ok || w_to_err) begin
                r_adc_num <= 8'd0;
            end else if (r_state == ST_LAST) begin
                r_adc_num <= r_adc_num + 8'd1;
            end

            if (w_to_err) begin
                r_err_code <= r_state;
            end

            if (w_start_ok) begin
                r_frame_cnt <= 16'd0;
            end else if (w_dtrx_ok) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign adc_num   = r_adc_num;
    assign err_code  = r_err_code;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_seq : directed scoreboard bench for adc_seq                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_adc_seq;
    import adc_seq_pkg::*;

    logic        sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst, start, mode, stop, err_clr, fifo_full;
    logic [7:0]  adc_cnt;
    logic        fs_check, fs_conf, fs_read, fs_fifo, fs_dtrx;
    logic        fd_check, fd_conf, fd_read, fd_fifo, fd_dtrx;
    logic [7:0]  adc_num, state_o, err_code;
    logic        busy, done, err;
    logic [15:0] frame_cnt;

    logic [4:0]  fs_v, fd_v, fd_en;
    int          age [5];

    assign fs_v = {fs_dtrx, fs_fifo, fs_read, fs_conf, fs_check};
    assign {fd_dtrx, fd_fifo, fd_read, fd_conf, fd_check} = fd_v;

    adc_seq #(
        .ADC_MAX (8),
        .TO_W    (16),
        .TIMEOUT (50)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .err_clr   (err_clr),
        .adc_cnt   (adc_cnt),
        .fifo_full (fifo_full),
        .fs_check  (fs_check),
        .fs_conf   (fs_conf),
        .fs_read   (fs_read),
        .fs_fifo   (fs_fifo),
        .fs_dtrx   (fs_dtrx),
        .fd_check  (fd_check),
        .fd_conf   (fd_conf),
        .fd_read   (fd_read),
        .fd_fifo   (fd_fifo),
        .fd_dtrx   (fd_dtrx),
        .adc_num   (adc_num),
        .state_o   (state_o),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    int          n_fitx = 0;
    int          n_dtrx = 0;
    int          n_done = 0;
    logic [7:0]  prev_state = 8'h00;

    // Sub-block model: each enabled fd_* pulses on the 2nd cycle its fs_* is high.
    initial begin
        fd_v = '0;
        for (int i = 0; i < 5; i++) age[i] = 0;
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < 5; i++) begin
                if (rst || !fs_v[i]) begin
                    age[i]  = 0;
                    fd_v[i] = 1'b0;
                end else begin
                    age[i]  = age[i] + 1;
                    fd_v[i] = fd_en[i] && (age[i] == 2);
                end
            end
        end
    end

    // Event capture: FITX entries tagged with channel, done pulses tagged with frame count.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (state_o == ST_FITX && prev_state != ST_FITX) begin
                n_fitx = n_fitx + 1;
                obs_q.push_back(32'hA000_0000 | 32'(adc_num));
            end
            if (state_o == ST_DTRX && prev_state != ST_DTRX) n_dtrx = n_dtrx + 1;
            if (done) begin
                n_done = n_done + 1;
                obs_q.push_back(32'hD000_0000 | 32'(frame_cnt));
            end
        end
        prev_state = state_o;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start(input logic m, input logic [7:0] c);
        mode    = m;
        adc_cnt = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_state(input logic [7:0] s, input string tag);
        int n = 0;
        while (state_o !== s && n < 600) begin
            tick();
            n++;
        end
        chk(tag, state_o, s);
    endtask

    task automatic wait_fc(input logic [15:0] v, input string tag);
        int n = 0;
        while (frame_cnt !== v && n < 600) begin
            tick();
            n++;
        end
        chk(tag, frame_cnt, v);
    endtask

    task automatic push_frame(input int nch);
        for (int c = 0; c < nch; c++) exp_q.push_back(32'hA000_0000 | 32'(c));
    endtask

    task automatic push_done(input int fc);
        exp_q.push_back(32'hD000_0000 | 32'(fc));
    endtask

    task automatic drain(input string tag);
        logic [31:0] o, e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 32'h0;
            chk(tag, o, e);
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int f0, d0, n0, cyc;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; err_clr = 1'b0;
        adc_cnt = 8'd0; fifo_full = 1'b0; fd_en = 5'h1F;

        tick();
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_outs", {busy, done, err, fs_v}, 8'h00);
        chk("rst_adc_num", adc_num, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick(2);

        // Single frame of 3 channels; mode/count changes after start must be ignored.
        push_frame(3); push_done(1);
        f0 = n_fitx; d0 = n_dtrx; n0 = n_done;
        pulse_start(1'b0, 8'd3);
        mode = 1'b1; adc_cnt = 8'd5;
        wait_state(ST_IDLE, "single_idle");
        chk("single_fitx", n_fitx - f0, 3);
        chk("single_dtrx", n_dtrx - d0, 1);
        chk("single_done", n_done - n0, 1);
        chk("single_fc", frame_cnt, 1);
        chk("single_busy", busy, 0);
        drain("single_sb");

        // Continuous, 2 channels, start ignored while busy, stop during 3rd frame.
        push_frame(2); push_frame(2); push_frame(2); push_done(3);
        d0 = n_dtrx; n0 = n_done;
        pulse_start(1'b1, 8'd2);
        mode = 1'b0;
        wait_fc(16'd1, "cont_fc1");
        pulse_start(1'b0, 8'd8);
        wait_fc(16'd2, "cont_fc2");
        stop = 1'b1; tick(); stop = 1'b0;
        wait_state(ST_IDLE, "cont_idle");
        chk("cont_fc", frame_cnt, 3);
        chk("cont_dtrx", n_dtrx - d0, 3);
        chk("cont_done", n_done - n0, 1);
        drain("cont_sb");

        // adc_cnt=0 maps to one channel.
        push_frame(1); push_done(1);
        f0 = n_fitx;
        pulse_start(1'b0, 8'd0);
        wait_state(ST_IDLE, "zero_idle");
        chk("zero_fitx", n_fitx - f0, 1);
        drain("zero_sb");

        // adc_cnt=20 clamps to ADC_MAX=8.
        push_frame(8); push_done(1);
        f0 = n_fitx;
        pulse_start(1'b0, 8'd20);
        wait_state(ST_IDLE, "clamp_idle");
        chk("clamp_fitx", n_fitx - f0, 8);
        drain("clamp_sb");

        // Backpressure in PREP.
        push_frame(1); push_done(1);
        fifo_full = 1'b1;
        pulse_start(1'b0, 8'd1);
        wait_state(ST_PREP, "bp_prep");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", state_o, ST_PREP);
            tick();
        end
        fifo_full = 1'b0;
        tick();
        chk("bp_fitx", state_o, ST_FITX);
        wait_state(ST_IDLE, "bp_idle");
        drain("bp_sb");

        // Timeout in CONF with fd_conf withheld.
        n0 = n_done;
        fd_en = 5'b11101;
        pulse_start(1'b0, 8'd1);
        wait_state(ST_CONF, "to_conf");
        cyc = 0;
        while (state_o == ST_CONF && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("to_cycles", cyc, 50);
        chk("to_state", state_o, ST_ERR);
        chk("to_err", err, 1);
        chk("to_err_code", err_code, 8'h02);
        chk("to_busy", busy, 1);
        chk("to_adc_num", adc_num, 0);
        pulse_start(1'b0, 8'd1);
        chk("to_start_ignored", state_o, ST_ERR);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("to_clr_state", state_o, ST_IDLE);
        chk("to_clr_err", err, 0);
        chk("to_no_done", n_done - n0, 0);
        fd_en = 5'h1F;
        drain("to_sb");

        // Reset in FIRX of channel 1.
        push_frame(2);
        n0 = n_done;
        pulse_start(1'b0, 8'd3);
        cyc = 0;
        while (!(state_o == ST_FIRX && adc_num == 8'd1) && cyc < 300) begin
            cyc++;
            tick();
        end
        chk("mid_firx1", {state_o, adc_num}, {ST_FIRX, 8'd1});
        rst = 1'b1;
        #1;
        chk("mid_state", state_o, ST_IDLE);
        chk("mid_outs", {busy, done, err, fs_v}, 8'h00);
        chk("mid_adc_num", adc_num, 0);
        chk("mid_fc", frame_cnt, 0);
        chk("mid_err_code", err_code, 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("mid_no_done", n_done - n0, 0);
        chk("mid_idle", state_o, ST_IDLE);
        drain("mid_sb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
